// File: rtl/jacobi_input_loader.sv
// rtl/jacobi_input_loader.sv - loads the 36 upper-triangle A words, then writes an 8x8 identity V matrix.
module jacobi_input_loader #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 20,
  parameter int N_INPUT_DATA = 36,
  parameter int V_OFFSET     = 36,
  parameter int N            = 8,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [OUT_WIDTH-1:0]  mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, LOAD_A, INIT_V, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(N_INPUT_DATA - 1);
  localparam logic [ADDR_WIDTH-1:0] N_V       = ADDR_WIDTH'(N * N);
  localparam logic [ADDR_WIDTH-1:0] DIAG_WRAP = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] V_BASE    = ADDR_WIDTH'(V_OFFSET);
  // 1.0 in the 15-fraction-bit memory format
  localparam logic [OUT_WIDTH-1:0]  ONE       = OUT_WIDTH'(1) << (IN_WIDTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] diag;
  logic                  accept;

  assign s_ready = (state == LOAD_A);
  assign busy    = (state != IDLE);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      diag      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_A;
            cnt   <= '0;
            diag  <= '0;
            err   <= 1'b0;
          end
        end
        LOAD_A: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt;
            mem_wdata <= {{(OUT_WIDTH-IN_WIDTH){s_data[IN_WIDTH-1]}}, s_data};
            // s_last must coincide exactly with the final beat
            if (s_last != (cnt == LAST_A)) err <= 1'b1;
            if (cnt == LAST_A) begin
              cnt   <= '0;
              state <= INIT_V;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        INIT_V: begin
          if (cnt == N_V) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= V_BASE + cnt;
            // diag walks 0..N, so it is zero exactly when j mod (N+1) == 0
            mem_wdata <= (diag == '0) ? ONE : '0;
            cnt       <= cnt + 1'b1;
            diag      <= (diag == DIAG_WRAP) ? '0 : diag + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jacobi_input_loader.md
JACOBI_INPUT_LOADER -- requirements
Module: jacobi_input_loader

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, input word width, Q(1.0.15).
REQ-002 SHALL have parameter OUT_WIDTH, default 20, memory word width, Q(1.4.15).
REQ-003 SHALL have parameter N_INPUT_DATA, default 36, number of upper-triangle words of the 8x8 symmetric matrix.
REQ-004 SHALL have parameter V_OFFSET, default 36, base memory address of the V matrix.
REQ-005 SHALL have parameter N, default 8, matrix size.
REQ-006 SHALL have parameter ADDR_WIDTH, default 7, memory address width.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, one-cycle load request.
REQ-010 SHALL have port s_valid, input, 1, input word valid.
REQ-011 SHALL have port s_ready, output, 1, loader accepts an input word.
REQ-012 SHALL have port s_data, input, IN_WIDTH, signed input word.
REQ-013 SHALL have port s_last, input, 1, marks the final input word.
REQ-014 SHALL have port mem_we, output, 1, memory write enable.
REQ-015 SHALL have port mem_addr, output, ADDR_WIDTH, memory write address.
REQ-016 SHALL have port mem_wdata, output, OUT_WIDTH, memory write data.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when the load is complete.
REQ-019 SHALL have port err, output, 1, sticky framing error; cleared by the next accepted start.

Function
REQ-020 SHALL implement the states IDLE, LOAD_A, INIT_V and DONE.
REQ-021 SHALL move from IDLE to LOAD_A on start=1, clear err and the word counter at the same edge, and ignore start in every other state.
REQ-022 SHALL drive s_ready=1 only in LOAD_A; a beat is accepted when s_valid=1 and s_ready=1.
REQ-023 SHALL, for accepted beat k (0..35), drive mem_we=1, mem_addr=k and mem_wdata=sign-extended s_data in the following cycle, giving a fixed latency of 1 cycle; registered outputs hold no bubbles when s_valid stays high.
REQ-024 SHALL use 4-bit sign extension for the conversion, with no scaling, because both formats carry 15 fraction bits.
REQ-025 SHALL leave LOAD_A for INIT_V after accepting beat 35, regardless of s_last.
REQ-026 SHALL set err when s_last=1 on a beat k<35, or when s_last=0 on beat 35; the load SHALL still complete all 36 words.
REQ-027 SHALL write j=0..63 in INIT_V, one word per cycle with no backpressure, to address V_OFFSET+j.
REQ-028 SHALL use 32768 (1.0) as the INIT_V write data when j mod 9 == 0 (diagonal), and 0 otherwise.
REQ-029 SHALL make the INIT_V writes contiguous with the last A write: the j=0 write occurs the cycle after the beat-35 write.
REQ-030 SHALL enter DONE after j=63 is issued; done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-031 SHALL hold mem_we=0 in IDLE and DONE, and in LOAD_A during cycles with no accepted beat; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-032 SHALL issue exactly 100 writes per load (addresses 0..99, each written exactly once), and the address SHALL never exceed 99.
REQ-033 SHALL make busy combinational from state, with busy=1 in LOAD_A, INIT_V and DONE.

Reset
REQ-034 SHALL, on rst=1 at any time including mid-load, asynchronously force state IDLE, counters 0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and err=0.
REQ-035 SHALL leave a partial load aborted by reset incomplete, with no resume; a new start is required.

Verification
REQ-036 SHALL cover a back-to-back load: start, 36 beats with s_valid=1 continuously and s_last on beat 35 -> writes at addresses 0..99 on consecutive cycles, done 102 cycles after start, err=0.
REQ-037 SHALL cover sign extension: s_data=16'h8000 -> mem_wdata=20'hF8000; s_data=16'h7FFF -> 20'h07FFF.
REQ-038 SHALL cover V initialisation: addresses 36, 45, 54, ..., 99 receive 32768, and the other 56 V addresses receive 0.
REQ-039 SHALL cover a framing error: s_last on beat 10 -> err=1 sticky, 100 writes still issued, done pulses; the next start clears err.
REQ-040 SHALL cover backpressure: s_valid toggled randomly -> mem_we only follows accepted beats, and addresses stay contiguous 0..35.
REQ-041 SHALL cover mid-load reset: rst pulsed at beat 20 -> all outputs 0 immediately, and start is ignored while busy.
